axil_regfile_slave: RTL and testbench

//   Parametrised AXI4-Lite slave backed by a NUM_REGS x DATA_W register file.

---
 rtl/axil_regfile_slave_if.sv | 31 +++
 rtl/axil_regfile_slave.sv | 139 +++++++++++++
 tb/tb_axil_regfile_slave.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_regfile_slave_if.sv
// AXI4-Lite bus bundle for axil_regfile_slave: five channels, master/slave views.
interface axil_regfile_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  AWVALID, AWREADY;
  logic [ADDR_W-1:0]     AWADDR;
  logic [2:0]            AWPROT;
  logic                  WVALID, WREADY;
  logic [DATA_W-1:0]     WDATA;
  logic [DATA_W/8-1:0]   WSTRB;
  logic                  BVALID, BREADY;
  logic [1:0]            BRESP;
  logic                  ARVALID, ARREADY;
  logic [ADDR_W-1:0]     ARADDR;
  logic [2:0]            ARPROT;
  logic                  RVALID, RREADY;
  logic [DATA_W-1:0]     RDATA;
  logic [1:0]            RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave over a NUM_REGS x DATA_W register file with byte strobes and SLVERR decode.
// Optional AXIL_PROT_CHECK_EN: unprivileged (AxPROT[0]=0) accesses get SLVERR and no effect.
module axil_regfile_slave #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  axil_regfile_slave_if.slave        s_axil,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr
);
  localparam int STRB_W = DATA_W/8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        prot;
  } addr_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wdat_req_t;

  logic                             run;
  logic                             aw_full, w_full, bvalid, rvalid;
  addr_req_t                        aw_q, aw_cur;
  wdat_req_t                        w_q, w_cur;
  logic [1:0]                       bresp, rresp;
  logic [DATA_W-1:0]                rdata, rd_data;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
  logic                             awready, wready, arready;
  logic                             aw_hs, w_hs, ar_hs, do_commit;
  logic [ADDR_W-1:0]                wr_idx, rd_idx;
  logic                             wr_prot_ok, rd_prot_ok, wr_ok, rd_ok;
  logic [NUM_REGS-1:0]              wr_hit;
  logic                             unused;

  // run holds READY low through reset and for the edge that releases it
  assign awready = run && !aw_full && !bvalid;
  assign wready  = run && !w_full  && !bvalid;
  assign arready = run && !rvalid;
  assign aw_hs   = s_axil.AWVALID && awready;
  assign w_hs    = s_axil.WVALID  && wready;
  assign ar_hs   = s_axil.ARVALID && arready;

  assign s_axil.AWREADY = awready;
  assign s_axil.WREADY  = wready;
  assign s_axil.ARREADY = arready;
  assign s_axil.BVALID  = bvalid;
  assign s_axil.BRESP   = bresp;
  assign s_axil.RVALID  = rvalid;
  assign s_axil.RDATA   = rdata;
  assign s_axil.RRESP   = rresp;
  assign reg_q          = regs;

  // A channel arriving this cycle is used directly so commit lands one edge after the last handshake
  assign aw_cur    = aw_full ? aw_q : addr_req_t'{s_axil.AWADDR, s_axil.AWPROT};
  assign w_cur     = w_full  ? w_q  : wdat_req_t'{s_axil.WDATA, s_axil.WSTRB};
  assign do_commit = (aw_full || aw_hs) && (w_full || w_hs);

  assign wr_idx = aw_cur.addr >> OFFS;
  assign rd_idx = s_axil.ARADDR >> OFFS;

`ifdef AXIL_PROT_CHECK_EN
  assign wr_prot_ok = aw_cur.prot[0];
  assign rd_prot_ok = s_axil.ARPROT[0];
`else
  assign wr_prot_ok = 1'b1;
  assign rd_prot_ok = 1'b1;
`endif
  assign unused = ^{aw_cur.prot, s_axil.ARPROT};

  assign wr_ok = (wr_idx < ADDR_W'(NUM_REGS)) && wr_prot_ok;
  assign rd_ok = (rd_idx < ADDR_W'(NUM_REGS)) && rd_prot_ok;

  always_comb begin
    wr_hit  = '0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = do_commit && wr_ok && (|w_cur.strb) && (wr_idx == ADDR_W'(i));
      if (rd_idx == ADDR_W'(i)) rd_data = regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run     <= 1'b0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_q    <= '0;
      w_q     <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      regs    <= '0;
      reg_wr  <= '0;
    end else begin
      run    <= 1'b1;
      reg_wr <= wr_hit;
      for (int i = 0; i < NUM_REGS; i++)
        for (int k = 0; k < STRB_W; k++)
          if (wr_hit[i] && w_cur.strb[k]) regs[i][k*8 +: 8] <= w_cur.data[k*8 +: 8];
      if (do_commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (bvalid && s_axil.BREADY) bvalid <= 1'b0;
        if (aw_hs) begin
          aw_full <= 1'b1;
          aw_q    <= aw_cur;
        end
        if (w_hs) begin
          w_full <= 1'b1;
          w_q    <= w_cur;
        end
      end
    end
  end

  // Read samples regs before any same-edge write lands, so it sees the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_ok ? rd_data : '0;
      rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid && s_axil.RREADY) begin
      rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_regfile_slave.sv
// Bench for axil_regfile_slave: vector table, directed corner sequences, randomized ops vs array model.
module tb_axil_regfile_slave;
  localparam int DW = 32, AW = 32, NR = 8;
`ifdef AXIL_PROT_CHECK_EN
  localparam bit PROT_CHK = 1'b1;
`else
  localparam bit PROT_CHK = 1'b0;
`endif
  typedef logic [NR*DW-1:0] cv_t;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  axil_regfile_slave_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  cv_t            reg_q;
  logic [NR-1:0]  reg_wr;

  axil_regfile_slave #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .s_axil(bus), .reg_q(reg_q), .reg_wr(reg_wr)
  );

  int checks = 0, errors = 0;
  logic [31:0] mregs [NR];

  task automatic chk(input string name, input cv_t act, input cv_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, data, input logic [3:0] strb,
                             input logic [2:0] prot, output logic [1:0] resp, output logic [NR-1:0] wr);
    logic [31:0] idx = addr >> 2;
    bit ok = (idx < NR) && (!PROT_CHK || prot[0]);
    resp = ok ? 2'b00 : 2'b10;
    wr = '0;
    if (ok && strb != 0) begin
      wr[idx] = 1'b1;
      for (int k = 0; k < 4; k++) if (strb[k]) mregs[idx][k*8 +: 8] = data[k*8 +: 8];
    end
  endtask

  task automatic model_read(input logic [31:0] addr, input logic [2:0] prot,
                            output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] idx = addr >> 2;
    bit ok = (idx < NR) && (!PROT_CHK || prot[0]);
    resp = ok ? 2'b00 : 2'b10;
    data = ok ? mregs[idx] : 32'h0;
  endtask

  function automatic cv_t model_flat();
    cv_t f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mregs[i];
    return f;
  endfunction

  // Drives AW and W independently, returns what was seen on the first BVALID cycle
  task automatic axi_write(input logic [31:0] addr, data, input logic [3:0] strb, input logic [2:0] prot,
                           input int aw_dly, w_dly, b_dly, output logic [1:0] resp,
                           output logic [NR-1:0] pulse, output cv_t q, output int lat, output bit held_ok);
    bit to = 0;
    fork
      begin
        int n = 0;
        repeat (aw_dly) @(posedge clk);
        #1 bus.AWVALID = 1'b1; bus.AWADDR = addr; bus.AWPROT = prot;
        @(negedge clk);
        while (!bus.AWREADY && n < 50) begin n++; @(negedge clk); end
        if (!bus.AWREADY) to = 1;
        @(posedge clk); #1 bus.AWVALID = 1'b0;
      end
      begin
        int n = 0;
        repeat (w_dly) @(posedge clk);
        #1 bus.WVALID = 1'b1; bus.WDATA = data; bus.WSTRB = strb;
        @(negedge clk);
        while (!bus.WREADY && n < 50) begin n++; @(negedge clk); end
        if (!bus.WREADY) to = 1;
        @(posedge clk); #1 bus.WVALID = 1'b0;
      end
    join
    chk("write handshake timeout", cv_t'(to), cv_t'(0));
    lat = 0;
    @(negedge clk);
    while (!bus.BVALID && lat < 50) begin lat++; @(negedge clk); end
    resp = bus.BRESP; pulse = reg_wr; q = reg_q;
    held_ok = 1;
    repeat (b_dly) begin
      @(negedge clk);
      if (!bus.BVALID || bus.BRESP !== resp || bus.AWREADY || bus.WREADY || reg_wr != 0) held_ok = 0;
    end
    @(posedge clk); #1 bus.BREADY = 1'b1;
    @(posedge clk); #1 bus.BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [2:0] prot, input int ar_dly, r_dly,
                          output logic [31:0] data, output logic [1:0] resp, output int lat, output bit held_ok);
    int n = 0;
    repeat (ar_dly) @(posedge clk);
    #1 bus.ARVALID = 1'b1; bus.ARADDR = addr; bus.ARPROT = prot;
    @(negedge clk);
    while (!bus.ARREADY && n < 50) begin n++; @(negedge clk); end
    chk("read handshake timeout", cv_t'(bus.ARREADY), cv_t'(1));
    @(posedge clk); #1 bus.ARVALID = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.RVALID && lat < 50) begin lat++; @(negedge clk); end
    data = bus.RDATA; resp = bus.RRESP;
    held_ok = 1;
    repeat (r_dly) begin
      @(negedge clk);
      if (!bus.RVALID || bus.RDATA !== data || bus.RRESP !== resp || bus.ARREADY) held_ok = 0;
    end
    @(posedge clk); #1 bus.RREADY = 1'b1;
    @(posedge clk); #1 bus.RREADY = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t         tbl [12];
    logic [1:0]   resp, eresp;
    logic [31:0]  rd, erd;
    logic [NR-1:0] pulse, epulse;
    cv_t          q;
    int           lat;
    bit           held, seen;

    tbl[0]  = '{1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    tbl[1]  = '{0, 32'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    tbl[2]  = '{1, 32'h08, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
    tbl[3]  = '{1, 32'h08, 32'h12345678, 4'h3, 2'b00, 32'h0};
    tbl[4]  = '{0, 32'h08, 32'h0,        4'h0, 2'b00, 32'hFFFF5678};
    tbl[5]  = '{0, 32'h40, 32'h0,        4'h0, 2'b10, 32'h0};
    tbl[6]  = '{1, 32'h40, 32'h99999999, 4'hF, 2'b10, 32'h0};
    tbl[7]  = '{1, 32'h0C, 32'hAABBCCDD, 4'h0, 2'b00, 32'h0};
    tbl[8]  = '{0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'h0};
    tbl[9]  = '{0, 32'h1F, 32'h0,        4'h0, 2'b00, 32'h0};
    tbl[10] = '{1, 32'h1E, 32'h11223344, 4'hC, 2'b00, 32'h0};
    tbl[11] = '{0, 32'h1C, 32'h0,        4'h0, 2'b00, 32'h11220000};

    bus.AWVALID = 0; bus.AWADDR = 0; bus.AWPROT = 0; bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0;
    bus.BREADY = 0; bus.ARVALID = 0; bus.ARADDR = 0; bus.ARPROT = 0; bus.RREADY = 0;
    for (int i = 0; i < NR; i++) mregs[i] = 0;

    // reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset readys", cv_t'({bus.AWREADY, bus.WREADY, bus.ARREADY}), cv_t'(0));
    chk("reset valids", cv_t'({bus.BVALID, bus.RVALID}), cv_t'(0));
    chk("reset resp/rdata", cv_t'({bus.BRESP, bus.RRESP, bus.RDATA}), cv_t'(0));
    chk("reset reg_q", reg_q, cv_t'(0));
    chk("reset reg_wr", cv_t'(reg_wr), cv_t'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post-reset readys", cv_t'({bus.AWREADY, bus.WREADY, bus.ARREADY}), cv_t'(3'b111));
    @(posedge clk); #1;

    // vector table (prot=001 so results hold with or without the prot check)
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 3'b001, 0, 0, 0, resp, pulse, q, lat, held);
        model_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 3'b001, eresp, epulse);
        chk($sformatf("tbl%0d bresp", i), cv_t'(resp), cv_t'(tbl[i].exp_resp));
      end else begin
        axi_read(tbl[i].addr, 3'b001, 0, 0, rd, resp, lat, held);
        chk($sformatf("tbl%0d rresp", i), cv_t'(resp), cv_t'(tbl[i].exp_resp));
        chk($sformatf("tbl%0d rdata", i), cv_t'(rd), cv_t'(tbl[i].exp_rdata));
      end
    end
    chk("tbl reg_q", reg_q, model_flat());

    // same-cycle AW/W: one-cycle latency, pulse on reg1
    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, 0, resp, pulse, q, lat, held);
    model_write(32'h4, 32'hDEADBEEF, 4'hF, 3'b001, eresp, epulse);
    chk("t1 latency", cv_t'(lat), cv_t'(0));
    chk("t1 bresp", cv_t'(resp), cv_t'(0));
    chk("t1 reg_wr", cv_t'(pulse), cv_t'(8'h02));
    chk("t1 reg1", cv_t'(q[1*DW +: DW]), cv_t'(32'hDEADBEEF));

    // W first, AW three cycles later, low-half strobes
    axi_write(32'h8, 32'hFFFFFFFF, 4'hF, 3'b001, 0, 0, 0, resp, pulse, q, lat, held);
    model_write(32'h8, 32'hFFFFFFFF, 4'hF, 3'b001, eresp, epulse);
    axi_write(32'h8, 32'h12345678, 4'h3, 3'b001, 3, 0, 0, resp, pulse, q, lat, held);
    model_write(32'h8, 32'h12345678, 4'h3, 3'b001, eresp, epulse);
    chk("t2 latency", cv_t'(lat), cv_t'(0));
    chk("t2 reg2", cv_t'(q[2*DW +: DW]), cv_t'(32'hFFFF5678));
    chk("t2 reg_wr", cv_t'(pulse), cv_t'(8'h04));

    // out-of-range decode
    axi_read(32'h40, 3'b001, 0, 0, rd, resp, lat, held);
    chk("t3 rresp", cv_t'(resp), cv_t'(2'b10));
    chk("t3 rdata", cv_t'(rd), cv_t'(0));
    axi_write(32'h40, 32'h5A5A5A5A, 4'hF, 3'b001, 0, 0, 0, resp, pulse, q, lat, held);
    chk("t3 bresp", cv_t'(resp), cv_t'(2'b10));
    chk("t3 reg_wr", cv_t'(pulse), cv_t'(0));
    chk("t3 reg_q", q, model_flat());

    // B back-pressure for 5 cycles, then an immediate next write
    axi_write(32'hC, 32'h00000055, 4'hF, 3'b001, 0, 0, 5, resp, pulse, q, lat, held);
    model_write(32'hC, 32'h00000055, 4'hF, 3'b001, eresp, epulse);
    chk("t4 held", cv_t'(held), cv_t'(1));
    axi_write(32'h10, 32'h00000066, 4'hF, 3'b001, 0, 0, 0, resp, pulse, q, lat, held);
    model_write(32'h10, 32'h00000066, 4'hF, 3'b001, eresp, epulse);
    chk("t4 next latency", cv_t'(lat), cv_t'(0));
    chk("t4 next reg_q", q, model_flat());

    // R back-pressure
    axi_read(32'hC, 3'b001, 0, 4, rd, resp, lat, held);
    chk("r held", cv_t'(held), cv_t'(1));
    chk("r held data", cv_t'(rd), cv_t'(32'h55));

    // read and write commit to reg0 on the same edge
    axi_write(32'h0, 32'h1, 4'hF, 3'b001, 0, 0, 0, resp, pulse, q, lat, held);
    model_write(32'h0, 32'h1, 4'hF, 3'b001, eresp, epulse);
    fork
      begin
        logic [1:0] r5; logic [NR-1:0] p5; cv_t q5; int l5; bit h5;
        axi_write(32'h0, 32'h2, 4'hF, 3'b001, 0, 0, 0, r5, p5, q5, l5, h5);
        chk("t5 reg0 after", cv_t'(q5[DW-1:0]), cv_t'(32'h2));
      end
      begin
        logic [31:0] d5; logic [1:0] rr5; int l5; bit h5;
        axi_read(32'h0, 3'b001, 0, 0, d5, rr5, l5, h5);
        chk("t5 rdata old", cv_t'(d5), cv_t'(32'h1));
      end
    join
    model_write(32'h0, 32'h2, 4'hF, 3'b001, eresp, epulse);

    // unprivileged access
    axi_write(32'h0, 32'h77, 4'hF, 3'b000, 0, 0, 0, resp, pulse, q, lat, held);
    model_write(32'h0, 32'h77, 4'hF, 3'b000, eresp, epulse);
    chk("t6 prot0 bresp", cv_t'(resp), cv_t'(PROT_CHK ? 2'b10 : 2'b00));
    chk("t6 prot0 reg0", cv_t'(q[DW-1:0]), cv_t'(PROT_CHK ? 32'h2 : 32'h77));
    axi_read(32'h0, 3'b000, 0, 0, rd, resp, lat, held);
    chk("t6 prot0 rresp", cv_t'(resp), cv_t'(PROT_CHK ? 2'b10 : 2'b00));
    chk("t6 prot0 rdata", cv_t'(rd), cv_t'(PROT_CHK ? 32'h0 : 32'h77));
    axi_write(32'h0, 32'h88, 4'hF, 3'b001, 0, 0, 0, resp, pulse, q, lat, held);
    model_write(32'h0, 32'h88, 4'hF, 3'b001, eresp, epulse);
    chk("t6 prot1 bresp", cv_t'(resp), cv_t'(0));
    chk("t6 prot1 reg0", cv_t'(q[DW-1:0]), cv_t'(32'h88));

    // reset with AW buffered: the orphan AW must be dropped
    #1 bus.AWVALID = 1'b1; bus.AWADDR = 32'h14; bus.AWPROT = 3'b001;
    @(posedge clk); #1 bus.AWVALID = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < NR; i++) mregs[i] = 0;
    @(posedge clk); #1 bus.WVALID = 1'b1; bus.WDATA = 32'hBAD0BAD0; bus.WSTRB = 4'hF;
    @(posedge clk); #1 bus.WVALID = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (bus.BVALID) seen = 1; end
    chk("mid-reset no commit", cv_t'(seen), cv_t'(0));
    chk("mid-reset reg_q", reg_q, cv_t'(0));
    @(posedge clk); #1 bus.AWVALID = 1'b1; bus.AWADDR = 32'h18; bus.AWPROT = 3'b001;
    @(posedge clk); #1 bus.AWVALID = 1'b0;
    @(negedge clk);
    model_write(32'h18, 32'hBAD0BAD0, 4'hF, 3'b001, eresp, epulse);
    chk("mid-reset completion", cv_t'({bus.BVALID, reg_wr}), cv_t'({1'b1, epulse}));
    chk("mid-reset reg_q after", reg_q, model_flat());
    @(posedge clk); #1 bus.BREADY = 1'b1;
    @(posedge clk); #1 bus.BREADY = 1'b0;

    // randomized traffic against the array model
    for (int it = 0; it < 150; it++) begin
      logic [31:0] a = 32'($urandom_range(0, 47));
      logic [31:0] d = $urandom;
      logic [3:0]  s = 4'($urandom_range(0, 15));
      logic [2:0]  p = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, d, s, p, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  resp, pulse, q, lat, held);
        model_write(a, d, s, p, eresp, epulse);
        chk("rnd bresp", cv_t'(resp), cv_t'(eresp));
        chk("rnd reg_wr", cv_t'(pulse), cv_t'(epulse));
        chk("rnd reg_q", q, model_flat());
        chk("rnd wlat", cv_t'(lat), cv_t'(0));
      end else begin
        axi_read(a, p, $urandom_range(0, 2), $urandom_range(0, 2), rd, resp, lat, held);
        model_read(a, p, erd, eresp);
        chk("rnd rresp", cv_t'(resp), cv_t'(eresp));
        chk("rnd rdata", cv_t'(rd), cv_t'(erd));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
